// File: rtl/switch_cfg_ctrl.sv
// Config-write controller for the switch register bank: round-robin arbitration of
// buffer requests into the route LUT / dateline registers. Optional lock: SWITCH_CFG_LOCK_EN.
module switch_cfg_ctrl #(
  parameter int NUM_BUFFERS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int TABLE_SIZE   = 8,
  parameter int ENTRY_W      = 8,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_BUFFERS-1:0]         req_valid,
  input  logic [NUM_BUFFERS*ADDR_W-1:0]  req_addr,
  input  logic [NUM_BUFFERS*DATA_W-1:0]  req_data,
  output logic [NUM_BUFFERS-1:0]         req_ready,
  output logic [NUM_BUFFERS-1:0]         resp_valid,
  output logic                           resp_err,
  output logic                           err_sticky,
  output logic [TABLE_SIZE*ENTRY_W-1:0]  route_lut,
  output logic [NUM_OUTPORTS-1:0]        dateline,
  output logic                           busy
);

  localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [TABLE_SIZE*ENTRY_W-1:0]   route_lut_q, route_lut_d;
  logic [NUM_OUTPORTS-1:0]         dateline_q, dateline_d;
  logic                            err_sticky_q, err_sticky_d;
  logic                            err_q, err_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               data_q, data_d;
  logic [IDX_W-1:0]                idx_q, idx_d;

  logic                            any_req;
  logic [IDX_W-1:0]                win_idx;
  logic [ADDR_W-1:0]               sel_addr;
  logic [DATA_W-1:0]               sel_data;
  logic                            lut_hit, dl_hit, lock_hit, locked, wr_ok;
  logic                            unused_data;

  function automatic int wrap_idx(input int v);
    return (v >= NUM_BUFFERS) ? v - NUM_BUFFERS : v;
  endfunction

  // rr_ptr_q holds the first index to search, i.e. last grant + 1
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (!any_req && req_valid[wrap_idx(int'(rr_ptr_q) + i)]) begin
        any_req  = 1'b1;
        win_idx  = IDX_W'(wrap_idx(int'(rr_ptr_q) + i));
        sel_addr = req_addr[wrap_idx(int'(rr_ptr_q) + i)*ADDR_W +: ADDR_W];
        sel_data = req_data[wrap_idx(int'(rr_ptr_q) + i)*DATA_W +: DATA_W];
      end
    end
  end

  assign lut_hit = (addr_q < ADDR_W'(TABLE_SIZE));
  assign dl_hit  = (addr_q == ADDR_W'(TABLE_SIZE));
  assign wr_ok   = !locked && (lut_hit || dl_hit || lock_hit);

`ifdef SWITCH_CFG_LOCK_EN
  logic lock_q, lock_d;

  assign lock_hit = (addr_q == ADDR_W'(TABLE_SIZE + 1));
  assign locked   = lock_q;

  always_comb begin
    lock_d = lock_q;
    if (state_q == WRITE && wr_ok && lock_hit && data_q[0]) lock_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`else
  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    route_lut_d  = route_lut_q;
    dateline_d   = dateline_q;
    err_sticky_d = err_sticky_q;
    err_d        = err_q;
    addr_d       = addr_q;
    data_d       = data_q;
    idx_d        = idx_q;
    req_ready    = '0;
    resp_valid   = '0;
    resp_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready[win_idx] = 1'b1;
          addr_d  = sel_addr;
          data_d  = sel_data;
          idx_d   = win_idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        rr_ptr_d = (idx_q == IDX_W'(NUM_BUFFERS - 1)) ? '0 : idx_q + 1'b1;
        err_d    = !wr_ok;
        if (wr_ok && lut_hit) begin
          for (int k = 0; k < TABLE_SIZE; k++) begin
            if (addr_q == ADDR_W'(k)) route_lut_d[k*ENTRY_W +: ENTRY_W] = data_q[ENTRY_W-1:0];
          end
        end
        if (wr_ok && dl_hit) dateline_d = data_q[NUM_OUTPORTS-1:0];
        state_d = RESP;
      end
      RESP: begin
        resp_valid[idx_q] = 1'b1;
        resp_err          = err_q;
        err_sticky_d      = err_sticky_q | err_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      route_lut_q  <= '0;
      dateline_q   <= '0;
      err_sticky_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      route_lut_q  <= route_lut_d;
      dateline_q   <= dateline_d;
      err_sticky_q <= err_sticky_d;
      err_q        <= err_d;
    end
  end

  // Request payload is only meaningful while busy, so it carries no reset
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    idx_q  <= idx_d;
  end

  assign unused_data = ^data_q;

  assign route_lut  = route_lut_q;
  assign dateline   = dateline_q;
  assign err_sticky = err_sticky_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// Directed bench for switch_cfg_ctrl: reset, LUT/dateline writes, arbitration order,
// rejected addresses, reset during WRITE and (when SWITCH_CFG_LOCK_EN) the lock register.
module tb_switch_cfg_ctrl;

  logic        clk;
  logic        n_rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic        resp_err;
  logic        err_sticky;
  logic [63:0] route_lut;
  logic [3:0]  dateline;
  logic        busy;

  int total = 0;
  int bad   = 0;

  switch_cfg_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .err_sticky (err_sticky),
    .route_lut  (route_lut),
    .dateline   (dateline),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int i, input logic [3:0] a, input logic [15:0] d);
    req_valid[i]         = 1'b1;
    req_addr[i*4 +: 4]   = a;
    req_data[i*16 +: 16] = d;
  endtask

  // One isolated write: accept, WRITE, RESP, back to IDLE
  task automatic single_write(input string tag, input int i, input logic [3:0] a,
                              input logic [15:0] d, input logic exp_err);
    drive(i, a, d);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(1) << i);
    tick();
    req_valid[i] = 1'b0;
    tick();
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(1) << i);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'(exp_err));
    tick();
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    n_rst     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lut", route_lut, 64'd0);
    chk("rst_dateline", 64'(dateline), 64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    n_rst = 1'b1;
    tick();

    // req 0 writes LUT entry 3 with 0xA5
    drive(0, 4'd3, 16'h00A5);
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("t1_busy_write", 64'(busy), 64'd1);
    chk("t1_lut_pending", route_lut, 64'd0);
    tick();
    chk("t1_lut", route_lut, 64'h00000000_A5000000);
    chk("t1_resp_valid", 64'(resp_valid), 64'h1);
    chk("t1_resp_err", 64'(resp_err), 64'd0);
    chk("t1_busy_resp", 64'(busy), 64'd1);
    tick();
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_resp_done", 64'(resp_valid), 64'd0);

    // fresh reset so the round-robin pointer starts at requester 0
    n_rst = 1'b0;
    #1;
    chk("t2_rst_lut", route_lut, 64'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // all four requesters hold requests continuously
    drive(0, 4'd0, 16'h0011);
    drive(1, 4'd1, 16'h0022);
    drive(2, 4'd2, 16'h0033);
    drive(3, 4'd4, 16'h0044);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_grant%0d", k), 64'(req_ready), 64'(1) << k);
      tick();
      req_valid[k] = 1'b0;
      #1;
      chk($sformatf("t2_hold%0d", k), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("t2_resp%0d", k), 64'(resp_valid), 64'(1) << k);
      tick();
    end
    chk("t2_lut", route_lut, 64'h00000044_00332211);

    // dateline write
    single_write("t3", 2, 4'd8, 16'h000B, 1'b0);
    chk("t3_dateline", 64'(dateline), 64'hB);

    // out-of-range address is rejected and sets the sticky flag
    single_write("t4", 1, 4'd12, 16'hFFFF, 1'b1);
    chk("t4_lut", route_lut, 64'h00000044_00332211);
    chk("t4_dateline", 64'(dateline), 64'hB);
    chk("t4_sticky", 64'(err_sticky), 64'd1);

    // same address again: last write wins, sticky stays set
    single_write("t5", 3, 4'd0, 16'h0077, 1'b0);
    chk("t5_lut", route_lut, 64'h00000044_00332277);
    chk("t5_sticky", 64'(err_sticky), 64'd1);

`ifdef SWITCH_CFG_LOCK_EN
    single_write("t6_lock", 0, 4'd9, 16'h0001, 1'b0);
    single_write("t6_locked", 0, 4'd0, 16'h0011, 1'b1);
    chk("t6_lut", route_lut, 64'h00000044_00332277);
`else
    single_write("t6_addr9", 0, 4'd9, 16'h0001, 1'b1);
    chk("t6_lut", route_lut, 64'h00000044_00332277);
`endif

    // reset while a write sits in WRITE
    drive(0, 4'd1, 16'h0099);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("t7_in_write", 64'(busy), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_lut", route_lut, 64'd0);
    chk("t7_dateline", 64'(dateline), 64'd0);
    chk("t7_sticky", 64'(err_sticky), 64'd0);
    chk("t7_resp", 64'(resp_valid), 64'd0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("t7_resp_after", 64'(resp_valid), 64'd0);
    chk("t7_busy_after", 64'(busy), 64'd0);
    chk("t7_lut_after", route_lut, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_cfg_ctrl.md
Name: switch_cfg_ctrl

Overview:
Configuration controller for the switch register bank: arbitrates config-write requests from NUM_BUFFERS input buffers and sequences each accepted write into the route lookup table or the dateline register.
- Round-robin arbitration; one write in flight at a time.
- Drives the registered route_lut / dateline state consumed by the switch routing and VC-allocation logic.
- Reports per-requester completion and a sticky address-error flag.

Parameters:
NUM_BUFFERS, 4, number of requesters (input buffers)
NUM_OUTPORTS, 4, width of dateline register (one bit per outport)
TABLE_SIZE, 8, number of route LUT entries
ENTRY_W, 8, width of one route LUT entry
DATA_W, 16, request data width; must be >= max(ENTRY_W, NUM_OUTPORTS)
ADDR_W, 4, request address width; must satisfy 2**ADDR_W > TABLE_SIZE

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
req_valid  input  NUM_BUFFERS  per-requester write request
req_addr  input  NUM_BUFFERS*ADDR_W  per-requester address, requester i at slice [i*ADDR_W +: ADDR_W]
req_data  input  NUM_BUFFERS*DATA_W  per-requester data, same packing
req_ready  output  NUM_BUFFERS  one-hot accept strobe
resp_valid  output  NUM_BUFFERS  one-hot completion pulse
resp_err  output  1  qualifies resp_valid: 1 = write rejected
err_sticky  output  1  set on any rejected write; cleared only by reset
route_lut  output  TABLE_SIZE*ENTRY_W  LUT entries, entry k at [k*ENTRY_W +: ENTRY_W]
dateline  output  NUM_OUTPORTS  dateline flag per outport
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, n_rst=0): FSM=IDLE; rr pointer=0; route_lut=0; dateline=0; err_sticky=0; req_ready, resp_valid, resp_err, busy all 0.
- Address map:
  - 0..TABLE_SIZE-1: LUT entry; data[ENTRY_W-1:0] written.
  - TABLE_SIZE: dateline; data[NUM_OUTPORTS-1:0] written.
  - Any other address: rejected, no state change.
- FSM IDLE -> WRITE -> RESP -> IDLE; throughput one write per 3 cycles.
- IDLE:
  - If any req_valid, pick the winner by round robin, searching upward from (last_grant+1) mod NUM_BUFFERS.
  - req_ready[winner]=1 combinationally in that cycle; all other ready bits 0.
  - Latch addr, data and index; go to WRITE.
  - If no req_valid, stay in IDLE with all ready bits 0.
- WRITE:
  - At the end of this cycle, the target register is updated. route_lut / dateline change on the clock edge leaving WRITE, i.e. 2 edges after the accept edge.
  - rr pointer updated to the winner.
- RESP:
  - resp_valid[idx]=1 for exactly one cycle; resp_err=1 if the address was rejected, else 0.
  - On a rejected write, err_sticky is set at the end of RESP.
- Handshake: a requester holds valid/addr/data until it sees ready, then must drop or change them. A valid still high after ready is treated as a new request.
- Simultaneous requests: exactly one winner per IDLE cycle. With all NUM_BUFFERS requesting continuously, grant order is 0,1,2,3,0,...
- New requests during WRITE/RESP are ignored (ready=0) and wait; no request is lost or merged.
- Repeated writes to the same address: last write wins.
- Reset mid-operation: the in-flight write is dropped if reset asserts before the WRITE edge. No resp_valid is issued; outputs return to reset values.

Optional Feature:
SWITCH_CFG_LOCK_EN
- Defined:
  - Address TABLE_SIZE+1 is a lock register; writing data bit0=1 sets an internal lock. This requires 2**ADDR_W > TABLE_SIZE+1.
  - While locked, every write (including to the lock address) is rejected: resp_err=1, err_sticky set.
  - The lock clears only on reset.
- Undefined: address TABLE_SIZE+1 is an out-of-range address and is rejected like any other.

Test Plan:
- Reset, then req 0 writes addr 3 data 0x00A5 -> ready[0] on cycle 0; route_lut entry 3 = 0xA5 after the 2nd edge; resp_valid=4'b0001 with resp_err=0 on the 3rd cycle; busy high for 2 cycles.
- All 4 requesters valid to distinct LUT addrs held continuously -> grants in order 0,1,2,3, spaced 3 cycles apart; all 4 entries written; no lost writes.
- Req 2 writes addr 8 (TABLE_SIZE) data 0x000B -> dateline=4'b1011, resp_err=0.
- Req 1 writes addr 12 -> no state change; resp_valid[1] with resp_err=1; err_sticky=1 and stays 1 until n_rst.
- Assert n_rst low during WRITE -> no resp_valid; route_lut=0, dateline=0, busy=0 immediately (async).
- With SWITCH_CFG_LOCK_EN defined: write addr 9 data 1, then addr 0 data 0x11 -> second write gets resp_err=1 and entry 0 remains 0.
